// File: rtl/vcdemux_pkg.sv
// Shared constants for the receive-side VC demultiplexer: enables, VC geometry,
// flit width and default FIFO depth.
package vcdemux_pkg;

    localparam logic        ENABLE    = 1'b1;
    localparam logic        ENABLE_N  = 1'b0;

    localparam int unsigned NUM_VC    = 2;
    localparam int unsigned VC_W      = 1;

    localparam int unsigned FLIT_W    = 64;
    localparam int unsigned DEPTH_DEF = 4;

    // Pointer width for a power-of-two depth; never narrower than one bit.
    function automatic int unsigned ptr_w(input int unsigned depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/vcdemux_vcfifo.sv
// Single-VC first-word-fall-through FIFO with registered credit pulse per dequeue.
// With VCDEMUX_OVF_EN defined it also keeps a sticky overflow flag.
module vcfifo
    import vcdemux_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = FLIT_W,
    parameter int unsigned DEPTH      = DEPTH_DEF
) (
    input  logic                  clk,
    input  logic                  rst_,
    input  logic                  wr_en,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic                  rd_en,
    output logic                  valid,
    output logic [DATA_WIDTH-1:0] rd_data,
    output logic                  credit
`ifdef VCDEMUX_OVF_EN
    ,
    output logic                  ovf
`endif
);

    localparam int unsigned AW = ptr_w(DEPTH);
    localparam int unsigned CW = AW + 1;

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];
    logic [DATA_WIDTH-1:0] mem_d [DEPTH];
    logic [AW-1:0]         wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]         rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]         cnt_q, cnt_d;
    logic                  credit_q, credit_d;
    logic                  full, empty, do_rd, do_wr;
`ifdef VCDEMUX_OVF_EN
    logic                  ovf_q, ovf_d;
`endif

    // A full FIFO still accepts a write when the head leaves on the same edge.
    always_comb begin
        full     = (cnt_q == CW'(DEPTH));
        empty    = (cnt_q == CW'(0));
        do_rd    = rd_en && !empty;
        do_wr    = wr_en && (!full || do_rd);
        mem_d    = mem_q;
        if (do_wr) begin
            mem_d[wr_ptr_q] = wr_data;
        end
        wr_ptr_d = do_wr ? (wr_ptr_q + AW'(1)) : wr_ptr_q;
        rd_ptr_d = do_rd ? (rd_ptr_q + AW'(1)) : rd_ptr_q;
        cnt_d    = cnt_q + CW'(do_wr) - CW'(do_rd);
        credit_d = do_rd ? ENABLE : ENABLE_N;
`ifdef VCDEMUX_OVF_EN
        ovf_d    = ovf_q | (wr_en && full && !do_rd);
`endif
    end

    always_ff @(posedge clk) begin
        mem_q <= mem_d;
        if (!rst_) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
            credit_q <= 1'b0;
`ifdef VCDEMUX_OVF_EN
            ovf_q    <= 1'b0;
`endif
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
            credit_q <= credit_d;
`ifdef VCDEMUX_OVF_EN
            ovf_q    <= ovf_d;
`endif
        end
    end

    // Head presentation comes only from stored state; zero when empty.
    always_comb begin
        valid   = !empty;
        rd_data = valid ? mem_q[rd_ptr_q] : '0;
        credit  = credit_q;
`ifdef VCDEMUX_OVF_EN
        ovf     = ovf_q;
`endif
    end

endmodule

// File: rtl/vcdemux.sv
// Router input-port VC demultiplexer: steers link flits into two per-VC FIFOs
// and returns per-VC credits. VCDEMUX_OVF_EN adds the sticky oovf flags.
module vcdemux
    import vcdemux_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = FLIT_W,
    parameter int unsigned DEPTH      = DEPTH_DEF
) (
    input  logic                  clk,
    input  logic                  rst_,
    input  logic                  ivalid,
    input  logic [DATA_WIDTH-1:0] idata,
    input  logic [VC_W-1:0]       ivch,
    output logic                  ovalid0,
    output logic                  ovalid1,
    output logic [DATA_WIDTH-1:0] odata0,
    output logic [DATA_WIDTH-1:0] odata1,
    input  logic                  ird0,
    input  logic                  ird1,
    output logic [NUM_VC-1:0]     ocredit
`ifdef VCDEMUX_OVF_EN
    ,
    output logic [NUM_VC-1:0]     oovf
`endif
);

    logic wr_en0, wr_en1;

    always_comb begin
        wr_en0 = ivalid && (ivch == VC_W'(0));
        wr_en1 = ivalid && (ivch == VC_W'(1));
    end

    vcfifo #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (DEPTH)
    ) u_vc0 (
        .clk     (clk),
        .rst_    (rst_),
        .wr_en   (wr_en0),
        .wr_data (idata),
        .rd_en   (ird0),
        .valid   (ovalid0),
        .rd_data (odata0),
        .credit  (ocredit[0])
`ifdef VCDEMUX_OVF_EN
        ,
        .ovf     (oovf[0])
`endif
    );

    vcfifo #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (DEPTH)
    ) u_vc1 (
        .clk     (clk),
        .rst_    (rst_),
        .wr_en   (wr_en1),
        .wr_data (idata),
        .rd_en   (ird1),
        .valid   (ovalid1),
        .rd_data (odata1),
        .credit  (ocredit[1])
`ifdef VCDEMUX_OVF_EN
        ,
        .ovf     (oovf[1])
`endif
    );

endmodule
